// File: rtl/cod_decimal_to_bcd.sv
// 1-of-10 decimal line bus to BCD priority encoder with a zero-latency code path,
// plus a one-cycle registered copy and a sticky not-one-hot error flag.
module cod_decimal_to_bcd #(
   parameter logic [3:0] INVALID_CODE = 4'b1111
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] D,
   input  logic       clr,
   output logic [3:0] BCD,
   output logic       VALID,
   output logic [3:0] BCD_Q,
   output logic       VALID_Q,
   output logic       ERR
);

   logic [9:0] d_minus_one;

   assign d_minus_one = D - 10'd1;

   // Clearing the lowest set bit leaves zero only when exactly one bit was set.
   assign VALID = (D != 10'd0) && ((D & d_minus_one) == 10'd0);

   // Ascending scan: the last match is the highest set line.
   always_comb begin
      BCD = INVALID_CODE;
      for (int i = 0; i < 10; i++) begin
         if (D[i]) begin
            BCD = 4'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         BCD_Q   <= 4'b0000;
         VALID_Q <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         BCD_Q   <= BCD;
         VALID_Q <= VALID;
         if (clr) begin
            ERR <= 1'b0;
         end else if (!VALID) begin
            ERR <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cod_decimal_to_bcd.sv
// Directed bench for cod_decimal_to_bcd: combinational walk, priority cases,
// registered path, sticky error with clear, and asynchronous reset.
module tb_cod_decimal_to_bcd;

   logic       clk;
   logic       reset;
   logic [9:0] D;
   logic       clr;
   logic [3:0] BCD;
   logic       VALID;
   logic [3:0] BCD_Q;
   logic       VALID_Q;
   logic       ERR;

   int tests_run;
   int tests_failed;

   cod_decimal_to_bcd dut (
      .clk     (clk),
      .reset   (reset),
      .D       (D),
      .clr     (clr),
      .BCD     (BCD),
      .VALID   (VALID),
      .BCD_Q   (BCD_Q),
      .VALID_Q (VALID_Q),
      .ERR     (ERR)
   );

   task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // One rising edge; returns 2 time units after it with clk still high.
   task automatic tick();
      clk = 1'b0;
      #3;
      clk = 1'b1;
      #2;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      clk   = 1'b0;
      reset = 1'b0;
      D     = 10'd0;
      clr   = 1'b0;

      #1;
      check("rst_bcd_q",   BCD_Q,           4'b0000);
      check("rst_valid_q", {3'b0, VALID_Q}, 4'd0);
      check("rst_err",     {3'b0, ERR},     4'd0);
      #4;
      reset = 1'b1;
      #5;

      // Single-one walk, no clock edges.
      for (int i = 0; i < 10; i++) begin
         D = 10'd1 << i;
         #1;
         check($sformatf("walk_bcd_%0d", i),   BCD,           4'(i));
         check($sformatf("walk_valid_%0d", i), {3'b0, VALID}, 4'd1);
      end

      D = 10'd0;
      #1;
      check("zero_bcd",   BCD,           4'b1111);
      check("zero_valid", {3'b0, VALID}, 4'd0);
      tick();
      check("zero_bcd_q",   BCD_Q,           4'b1111);
      check("zero_valid_q", {3'b0, VALID_Q}, 4'd0);
      check("zero_err",     {3'b0, ERR},     4'd1);

      D = 10'b1000000001;
      #1;
      check("multi_9_0_bcd",   BCD,           4'b1001);
      check("multi_9_0_valid", {3'b0, VALID}, 4'd0);
      D = 10'b0000000110;
      #1;
      check("multi_2_1_bcd",   BCD,           4'b0010);
      check("multi_2_1_valid", {3'b0, VALID}, 4'd0);
      D = 10'b0000100101;
      #1;
      check("multi_5_2_0_bcd", BCD, 4'b0101);

      // Clear with a valid digit.
      D   = 10'd1 << 5;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_err",     {3'b0, ERR},     4'd0);
      check("clr_bcd_q",   BCD_Q,           4'b0101);
      check("clr_valid_q", {3'b0, VALID_Q}, 4'd1);

      // Clear wins over a same-cycle error.
      D   = 10'd0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_prio_err", {3'b0, ERR}, 4'd0);

      D = 10'd1 << 3;
      tick();
      check("seq3_bcd_q",   BCD_Q,           4'b0011);
      check("seq3_valid_q", {3'b0, VALID_Q}, 4'd1);
      check("seq3_err",     {3'b0, ERR},     4'd0);
      D = 10'd1 << 7;
      tick();
      check("seq7_bcd_q",   BCD_Q,           4'b0111);
      check("seq7_valid_q", {3'b0, VALID_Q}, 4'd1);
      check("seq7_err",     {3'b0, ERR},     4'd0);

      // Set ERR, then load 9 and confirm ERR is sticky.
      D = 10'b0000011000;
      tick();
      check("multi_err_set", {3'b0, ERR}, 4'd1);
      D = 10'd1 << 9;
      tick();
      check("pre_rst_bcd_q", BCD_Q,       4'b1001);
      check("pre_rst_err",   {3'b0, ERR}, 4'd1);

      // Asynchronous reset between edges.
      clk = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      check("arst_bcd_q",   BCD_Q,           4'b0000);
      check("arst_valid_q", {3'b0, VALID_Q}, 4'd0);
      check("arst_err",     {3'b0, ERR},     4'd0);
      D = 10'd1 << 4;
      #1;
      check("arst_bcd_track",   BCD,           4'b0100);
      check("arst_valid_track", {3'b0, VALID}, 4'd1);
      tick();
      check("arst_hold_bcd_q", BCD_Q, 4'b0000);

      clk = 1'b0;
      #2;
      reset = 1'b1;
      D = 10'd1 << 2;
      tick();
      check("post_rst_bcd_q",   BCD_Q,           4'b0010);
      check("post_rst_valid_q", {3'b0, VALID_Q}, 4'd1);
      check("post_rst_err",     {3'b0, ERR},     4'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cod_decimal_to_bcd.md
# cod_decimal_to_bcd

Encodes a 1-of-10 decimal digit line bus into a 4-bit BCD code, for keypad and digit-selector front-ends. The combinational code path has zero latency. A registered copy of the code and its validity, plus a sticky error flag, are provided for clocked consumers. The module name is `cod_decimal_to_bcd`.

## Interface
Parameters:
- `INVALID_CODE`, default 4'b1111: value driven on `BCD` when no input line is asserted.

Ports:
- `clk`  in  1  sole clock. All registered outputs update on its rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset). Clears all registered state immediately.
- `D`  in  10  decimal digit lines. Bit i asserted means digit i.
- `clr`  in  1  synchronous clear of the sticky `ERR` flag.
- `BCD`  out  4  combinational BCD code of `D`.
- `VALID`  out  1  combinational. High when `D` has exactly one bit set.
- `BCD_Q`  out  4  `BCD` registered.
- `VALID_Q`  out  1  `VALID` registered.
- `ERR`  out  1  sticky flag. Set by any sampled cycle in which `D` is not one-hot.

## Operation
Combinational path:
- Exactly one bit i set (i = 0..9): `BCD` = i in unsigned binary (0000..1001), `VALID` = 1.
- Multiple bits set: `BCD` = index of the highest set bit (priority encoding), `VALID` = 0.
  - Example: D = 10'b0000100101 gives `BCD` = 0101.
- `D` = 0: `BCD` = `INVALID_CODE`, `VALID` = 0.
- `BCD` never takes values 1010..1110. 1111 appears only through `INVALID_CODE`.
- `BCD` and `VALID` do not depend on `clk`, `reset` or `clr`.

Registered path, on each rising `clk` edge with `reset` = 1:
- `BCD_Q` <= `BCD`, `VALID_Q` <= `VALID`.
- `ERR` <= 0 if `clr` = 1. This clear takes precedence over setting.
- Otherwise `ERR` <= `ERR` | ~`VALID`.

## Timing
- `BCD` and `VALID` settle within the combinational delay after any change of `D`. No clock is required for them.
- `BCD_Q` and `VALID_Q` lag `D` by one rising edge. They show the code sampled at the last edge.
- `ERR` rises on the first edge that samples a non-one-hot `D`. It then holds until `clr` is sampled high or `reset` is asserted.
- Assertion of `reset` (low) forces `BCD_Q` = 0000, `VALID_Q` = 0 and `ERR` = 0 at once, without waiting for `clk`. These values hold while `reset` = 0.
- Deassertion of `reset` is synchronous-safe. The first edge after release samples normally.
- `clr` and a non-one-hot `D` in the same cycle leave `ERR` = 0.
- During reset, `BCD`/`VALID` keep tracking `D`.

## Test plan
- Walk a single 1 across D[0]..D[9]: `BCD` = 0000, 0001, …, 1001 respectively, each 1 time unit after `D` changes, with `VALID` = 1 and no clock running.
- Apply D = 0: `BCD` = 1111, `VALID` = 0. Clock one edge: `VALID_Q` = 0, `ERR` = 1.
- Apply D = 10'b1000000001: `BCD` = 1001, `VALID` = 0. Apply D = 10'b0000000110: `BCD` = 0010.
- Clocked sequence D = bit3, bit7: after each edge `BCD_Q` = 0011 then 0111 and `VALID_Q` = 1. `ERR` stays 0.
- With `ERR` = 1, pulse `clr` for one edge with D = bit5: `ERR` = 0. Repeat with D = 0 and `clr` = 1: `ERR` stays 0.
- Drive `reset` low between clock edges with `BCD_Q` = 1001 and `ERR` = 1: outputs become 0000/0/0 immediately, while `BCD` still follows `D`.
